// File: rtl/radiant_readout_scheduler_if.sv
// rtl/radiant_readout_scheduler_if.sv - header and LAB4 sequence handshake bundle
//
// Purpose: groups the header-writer handshake and the LAB4 sequence
// controller handshake of the readout scheduler into one port.
// Signals:
//   hdr_valid_o / hdr_ready_i / hdr_evnum_o : event header write request
//   seq_ready_i   : LAB4 controller able to start a sequence
//   seq_start_o   : one-cycle start pulse, seq_forced_o tags forced sequences
//   seq_done_i    : one-cycle pulse, sequence written into the FIFO
//   seq_drained_i : one-cycle pulse, one sequence removed from the FIFO
// master = scheduler side, slave = header writer / LAB4 controller side.
interface radiant_readout_scheduler_if;
  logic        hdr_valid_o;
  logic        hdr_ready_i;
  logic [31:0] hdr_evnum_o;
  logic        seq_ready_i;
  logic        seq_start_o;
  logic        seq_forced_o;
  logic        seq_done_i;
  logic        seq_drained_i;

  modport master (
    output hdr_valid_o, hdr_evnum_o, seq_start_o, seq_forced_o,
    input  hdr_ready_i, seq_ready_i, seq_done_i, seq_drained_i
  );

  modport slave (
    input  hdr_valid_o, hdr_evnum_o, seq_start_o, seq_forced_o,
    output hdr_ready_i, seq_ready_i, seq_done_i, seq_drained_i
  );
endinterface

// File: rtl/radiant_readout_scheduler.sv
// rtl/radiant_readout_scheduler.sv - LAB4 readout sequence scheduler
//
// Purpose: on each accepted trigger emits one event header, NSEQ readout
// sequences and a one-cycle readout_done; forced (pedestal/CalRam) sequences
// run between events with no header and no done. Tracks LAB4 FIFO occupancy
// in sequence units and back-pressures sequence starts when full.
// Ports:
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   en_i, nseq_i         : enable, sequences per event (0 means 1)
//   trig_i, force_req_i  : trigger level (rising edge counts), forced request
//   bus                  : header and sequence handshakes (master modport)
//   readout_running_o, readout_done_o, readout_full_o : overlord status
//   occupancy_o, force_pending_o, trig_lost_o, underflow_o : status
module radiant_readout_scheduler #(
  parameter int DEPTH  = 8,
  parameter int NSEQ_W = 4
) (
  input  logic                        sys_clk_i,
  input  logic                        sys_rst_i,
  input  logic                        en_i,
  input  logic [NSEQ_W-1:0]           nseq_i,
  input  logic                        trig_i,
  input  logic                        force_req_i,
  radiant_readout_scheduler_if.master bus,
  output logic                        readout_running_o,
  output logic                        readout_done_o,
  output logic                        readout_full_o,
  output logic [7:0]                  occupancy_o,
  output logic                        force_pending_o,
  output logic                        trig_lost_o,
  output logic                        underflow_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  state_t            state_q, state_d;
  logic [NSEQ_W-1:0] rem_q, rem_d;
  logic              forced_q, forced_d;
  logic              trig_d;
  logic              trig_pend;
  logic              force_pend;
  logic [31:0]       evnum_q;
  logic [7:0]        occ_q;

  logic trig_edge;
  logic take_trig;
  logic take_force;
  logic hdr_valid;
  logic seq_start;
  logic done_pulse;
  logic drain_ok;

  // Edges seen while disabled are dropped outright, never counted as lost.
  assign trig_edge = trig_i && !trig_d && en_i;
  assign drain_ok  = bus.seq_drained_i && (occ_q != 8'd0);

  assign readout_full_o   = (occ_q == DEPTH_C);
  assign occupancy_o      = occ_q;
  assign force_pending_o  = force_pend;
  assign readout_done_o   = done_pulse;
  assign bus.hdr_valid_o  = hdr_valid;
  assign bus.hdr_evnum_o  = evnum_q;
  assign bus.seq_start_o  = seq_start;
  assign bus.seq_forced_o = seq_start && forced_q;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    forced_d   = forced_q;
    take_trig  = 1'b0;
    take_force = 1'b0;
    hdr_valid  = 1'b0;
    seq_start  = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A pending trigger beats a pending forced request.
        if (trig_pend) begin
          take_trig = 1'b1;
          rem_d     = (nseq_i == '0) ? NSEQ_W'(1) : nseq_i;
          forced_d  = 1'b0;
          state_d   = S_HDR;
        end else if (force_pend) begin
          take_force = 1'b1;
          rem_d      = NSEQ_W'(1);
          forced_d   = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_HDR: begin
        hdr_valid = 1'b1;
        if (bus.hdr_ready_i) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.seq_ready_i && !readout_full_o) begin
          seq_start = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.seq_done_i) begin
          rem_d = rem_q - NSEQ_W'(1);
          if (rem_q == NSEQ_W'(1)) begin
            state_d = forced_q ? S_IDLE : S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done_pulse = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q           <= S_IDLE;
      rem_q             <= '0;
      forced_q          <= 1'b0;
      trig_d            <= 1'b0;
      trig_pend         <= 1'b0;
      force_pend        <= 1'b0;
      evnum_q           <= 32'd0;
      occ_q             <= 8'd0;
      readout_running_o <= 1'b0;
      trig_lost_o       <= 1'b0;
      underflow_o       <= 1'b0;
    end else begin
      state_q           <= state_d;
      rem_q             <= rem_d;
      forced_q          <= forced_d;
      trig_d            <= trig_i;
      readout_running_o <= en_i;
      // The pending slot is still occupied on the cycle it is taken, so an
      // edge landing then is lost like any other edge hitting a full slot.
      trig_lost_o       <= trig_edge && trig_pend;
      trig_pend         <= take_trig ? 1'b0 : (trig_pend || trig_edge);
      force_pend        <= take_force ? 1'b0 : (force_pend || force_req_i);
      if (done_pulse) begin
        evnum_q <= evnum_q + 32'd1;
      end
      case ({seq_start, drain_ok})
        2'b10:   occ_q <= occ_q + 8'd1;
        2'b01:   occ_q <= occ_q - 8'd1;
        default: occ_q <= occ_q;
      endcase
      if (bus.seq_drained_i && (occ_q == 8'd0)) begin
        underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_radiant_readout_scheduler.sv
// tb/tb_radiant_readout_scheduler.sv - bench for radiant_readout_scheduler
module tb_radiant_readout_scheduler;
  localparam int DEPTH  = 8;
  localparam int NSEQ_W = 4;
  localparam int C_NONE = 0;
  localparam int C_EVT  = 1;
  localparam int C_FRC  = 2;
  localparam int C_DONE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              trig = 1'b0;
  logic              force_req = 1'b0;
  logic [NSEQ_W-1:0] nseq = '0;
  logic              running, done, full, force_pending, lost, underflow;
  logic [7:0]        occ;

  radiant_readout_scheduler_if bus_if ();

  radiant_readout_scheduler #(.DEPTH(DEPTH), .NSEQ_W(NSEQ_W)) dut (
    .sys_clk_i        (clk),
    .sys_rst_i        (rst),
    .en_i             (en),
    .nseq_i           (nseq),
    .trig_i           (trig),
    .force_req_i      (force_req),
    .bus              (bus_if),
    .readout_running_o(running),
    .readout_done_o   (done),
    .readout_full_o   (full),
    .occupancy_o      (occ),
    .force_pending_o  (force_pending),
    .trig_lost_o      (lost),
    .underflow_o      (underflow)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Event counters, owned by this monitor only; tests work on deltas.
  int n_hdr = 0, n_start = 0, n_forced = 0, n_done = 0, n_lost = 0, done_at_forced = 0;
  int b_hdr, b_start, b_forced, b_done, b_lost;

  always @(negedge clk) begin
    if (bus_if.hdr_valid_o && bus_if.hdr_ready_i) n_hdr++;
    if (bus_if.seq_start_o) begin
      n_start++;
      if (bus_if.seq_forced_o) begin
        n_forced++;
        done_at_forced = n_done;
      end
    end
    if (done) n_done++;
    if (lost) n_lost++;
  end

  // LAB4 controller stand-in: seq_done a random 1..lat_max clocks after a start.
  logic auto_done = 1'b1;
  int   lat_max   = 1;
  int   resp_cnt  = 0;

  always @(posedge clk) begin
    #2;
    bus_if.seq_done_i = 1'b0;
    if (!auto_done) begin
      resp_cnt = 0;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) bus_if.seq_done_i = 1'b1;
    end
    if (auto_done && bus_if.seq_start_o) resp_cnt = $urandom_range(1, lat_max);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic snap();
    b_hdr = n_hdr; b_start = n_start; b_forced = n_forced; b_done = n_done; b_lost = n_lost;
  endtask

  task automatic pulse_trig(input int gap);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick(gap);
  endtask

  typedef struct {
    int nseq; int ntrig; bit frc;
    int hdr; int starts; int forced; int dn; int occ; bit full; int dord;
  } vec_t;
  vec_t vecs[6];

  // Transaction-level reference state for the randomized phase.
  int ctx, rem_m, occ_m, hdr_m, dn_m, lost_m, edges_m;
  bit out_m, under_m, trig_m, en_m;

  initial begin
    vecs[0] = '{3, 1, 0, 1, 3, 0, 1, 3, 0, 0};
    vecs[1] = '{0, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    vecs[2] = '{3, 3, 0, 3, 8, 0, 2, 8, 1, 0};
    vecs[3] = '{2, 1, 1, 1, 3, 1, 1, 3, 0, 1};
    vecs[4] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0};
    vecs[5] = '{15, 1, 0, 1, 8, 0, 0, 8, 1, 0};

    bus_if.hdr_ready_i   = 1'b1;
    bus_if.seq_ready_i   = 1'b1;
    bus_if.seq_drained_i = 1'b0;

    // Reset state
    do_reset();
    check("rst_hdr_valid", bus_if.hdr_valid_o, 0);
    check("rst_seq_start", bus_if.seq_start_o, 0);
    check("rst_done", done, 0);
    check("rst_occ", occ, 0);
    check("rst_full", full, 0);
    check("rst_underflow", underflow, 0);
    check("rst_lost", lost, 0);
    check("rst_running", running, 0);
    check("rst_force_pending", force_pending, 0);
    check("rst_evnum", bus_if.hdr_evnum_o, 0);

    // Table-driven event scenarios, ready inputs high, no drains
    for (int i = 0; i < 6; i++) begin
      do_reset();
      nseq = NSEQ_W'(vecs[i].nseq);
      snap();
      for (int t = 0; t < ((vecs[i].ntrig > 0) ? vecs[i].ntrig : 1); t++) begin
        trig      = (vecs[i].ntrig > 0);
        force_req = vecs[i].frc && (t == 0);
        tick();
        trig      = 1'b0;
        force_req = 1'b0;
        tick(20);
      end
      tick(60);
      check($sformatf("v%0d_hdr", i), n_hdr - b_hdr, vecs[i].hdr);
      check($sformatf("v%0d_starts", i), n_start - b_start, vecs[i].starts);
      check($sformatf("v%0d_forced", i), n_forced - b_forced, vecs[i].forced);
      check($sformatf("v%0d_done", i), n_done - b_done, vecs[i].dn);
      check($sformatf("v%0d_occ", i), occ, vecs[i].occ);
      check($sformatf("v%0d_full", i), full, vecs[i].full);
      check($sformatf("v%0d_underflow", i), underflow, 0);
      if (vecs[i].forced > 0)
        check($sformatf("v%0d_forced_after_done", i), done_at_forced - b_done, vecs[i].dord);
    end

    // Held trigger level is a single event
    do_reset();
    nseq = 4'd1;
    snap();
    trig = 1'b1;
    tick(2);
    trig = 1'b0;
    tick(20);
    check("held_trig_hdr", n_hdr - b_hdr, 1);
    check("held_trig_lost", n_lost - b_lost, 0);

    // Three edges: first runs, second waits, third is lost
    do_reset();
    nseq = 4'd3;
    snap();
    for (int k = 0; k < 3; k++) pulse_trig(2);
    tick(60);
    check("burst_hdr", n_hdr - b_hdr, 2);
    check("burst_done", n_done - b_done, 2);
    check("burst_lost", n_lost - b_lost, 1);

    // FIFO full stall, then one drain releases the ninth start
    do_reset();
    nseq = 4'd3;
    snap();
    for (int k = 0; k < 3; k++) pulse_trig(20);
    tick(20);
    check("full_starts", n_start - b_start, 8);
    check("full_flag", full, 1);
    bus_if.seq_drained_i = 1'b1;
    tick();
    bus_if.seq_drained_i = 1'b0;
    tick(30);
    check("drain_starts", n_start - b_start, 9);
    check("drain_done", n_done - b_done, 3);
    check("drain_occ", occ, 8);

    // Underflow, then simultaneous start and drain
    do_reset();
    bus_if.seq_drained_i = 1'b1;
    tick();
    bus_if.seq_drained_i = 1'b0;
    check("uflow_occ", occ, 0);
    check("uflow_flag", underflow, 1);
    nseq = 4'd1;
    for (int k = 0; k < 4; k++) pulse_trig(12);
    tick(3);
    check("uflow_sticky", underflow, 1);
    bus_if.seq_ready_i = 1'b0;
    pulse_trig(8);
    check("stall_no_start", bus_if.seq_start_o, 0);
    check("stall_occ", occ, 4);
    bus_if.seq_ready_i   = 1'b1;
    bus_if.seq_drained_i = 1'b1;
    #1;
    check("both_start", bus_if.seq_start_o, 1);
    tick();
    bus_if.seq_drained_i = 1'b0;
    check("both_occ", occ, 4);
    tick(10);

    // Reset in the middle of an event, then header hold and latency
    do_reset();
    nseq = 4'd1;
    snap();
    for (int k = 0; k < 5; k++) pulse_trig(12);
    check("pre_evnum", bus_if.hdr_evnum_o, 5);
    auto_done = 1'b0;
    pulse_trig(12);
    check("wait_occ", occ, 6);
    check("wait_done", n_done - b_done, 5);
    snap();
    rst = 1'b1;
    tick();
    check("mid_rst_occ", occ, 0);
    check("mid_rst_evnum", bus_if.hdr_evnum_o, 0);
    check("mid_rst_start", bus_if.seq_start_o, 0);
    check("mid_rst_hdr_valid", bus_if.hdr_valid_o, 0);
    rst = 1'b0;
    auto_done = 1'b1;
    tick(3);
    check("mid_rst_no_done", n_done - b_done, 0);
    bus_if.hdr_ready_i = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("lat_hdr_1clk", bus_if.hdr_valid_o, 0);
    tick();
    check("lat_hdr_2clk", bus_if.hdr_valid_o, 1);
    tick(3);
    check("hold_hdr_valid", bus_if.hdr_valid_o, 1);
    check("hold_evnum", bus_if.hdr_evnum_o, 0);
    bus_if.hdr_ready_i = 1'b1;
    tick();
    check("lat_start", bus_if.seq_start_o, 1);
    tick(10);

    // Randomized traffic against the transaction-level model
    nseq    = 4'd2;
    lat_max = 4;
    en      = 1'b1;
    do_reset();
    snap();
    ctx = C_NONE; rem_m = 0; occ_m = 0; hdr_m = 0; dn_m = 0; lost_m = 0; edges_m = 0;
    out_m = 0; under_m = 0; trig_m = 0; en_m = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      check("rnd_running", running, en_m);
      check("rnd_occ", occ, occ_m);
      check("rnd_full", full, occ_m == DEPTH);
      check("rnd_underflow", underflow, under_m);
      check("rnd_done", done, ctx == C_DONE);
      if (ctx == C_DONE) begin
        ctx = C_NONE;
        dn_m++;
      end
      if (lost) lost_m++;
      if (bus_if.hdr_valid_o && bus_if.hdr_ready_i) begin
        check("rnd_hdr_ctx", ctx, C_NONE);
        check("rnd_hdr_evnum", bus_if.hdr_evnum_o, hdr_m);
        hdr_m++;
        ctx   = C_EVT;
        rem_m = 2;
        out_m = 0;
      end
      if (bus_if.seq_start_o) begin
        check("rnd_start_forced", bus_if.seq_forced_o, ctx == C_NONE);
        check("rnd_start_legal", (ctx == C_NONE) || (ctx == C_EVT && !out_m && rem_m > 0), 1);
        check("rnd_start_room", occ_m < DEPTH, 1);
        if (ctx == C_NONE) begin
          ctx   = C_FRC;
          rem_m = 1;
        end
        out_m = 1;
      end
      if (bus_if.seq_done_i && out_m) begin
        out_m = 0;
        rem_m--;
        if (rem_m == 0) ctx = (ctx == C_FRC) ? C_NONE : C_DONE;
      end
      if (bus_if.seq_drained_i && occ_m == 0) under_m = 1;
      occ_m = occ_m + int'(bus_if.seq_start_o) - int'(bus_if.seq_drained_i && occ_m != 0);
      if (trig && !trig_m && en) edges_m++;
      trig_m = trig;
      en_m   = en;

      @(posedge clk);
      #1;
      trig      = (c < 1600) && ($urandom_range(0, 11) == 0);
      force_req = (c < 1600) && ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      bus_if.hdr_ready_i   = ($urandom_range(0, 3) != 0);
      bus_if.seq_ready_i   = ($urandom_range(0, 3) != 0);
      bus_if.seq_drained_i = ($urandom_range(0, ((c % 300) < 150) ? 10 : 2) == 0);
    end
    check("rnd_end_idle", ctx, C_NONE);
    check("rnd_edges_accounted", hdr_m + lost_m, edges_m);
    check("rnd_done_per_hdr", dn_m, hdr_m);
    check("rnd_force_drained", force_pending, 0);
    check("rnd_forced_seen", (n_forced - b_forced) > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1);
  end

endmodule
